sysp_icb_xbar: RTL and testbench
================================

SYSP_ICB_XBAR -- requirements
Module: sysp_icb_xbar

Interface
REQ-001 SHALL have parameter SLOT_NUM, default 16: number of peripheral slots, range 1..16.
REQ-002 SHALL have parameter SEL_LSB, default 8: lowest address bit of the slot select field; also the slot offset width.
REQ-003 SHALL have parameter SEL_W, default 4: slot select field width; 2^SEL_W >= SLOT_NUM.
REQ-004 SHALL have parameter SLOT_MASK, default 16'h800F: bit i set means slot i is implemented.
REQ-005 SHALL have parameter TMO_CYC, default 255: slot wait-state limit in cycles, range 1..65535.
REQ-006 SHALL have ports: clk in 1 clock; rst in 1 synchronous active-high reset.
REQ-007 SHALL have ICB slave ports: icb_cmd_valid in 1; icb_cmd_ready out 1; icb_cmd_addr in 32; icb_cmd_read in 1; icb_cmd_wdata in 32; icb_cmd_wmask in 4; icb_rsp_valid out 1; icb_rsp_ready in 1; icb_rsp_err out 1; icb_rsp_rdata out 32.
REQ-008 SHALL have slot ports: slot_addr_o out SEL_LSB, word-aligned offset shared by all slots; slot_wdata_o out 32; slot_sel_o out 4; slot_we_o out SLOT_NUM; slot_rd_o out SLOT_NUM; slot_rdata_i in 32*SLOT_NUM, slot i at bits [32i+31:32i]; slot_rdy_i in SLOT_NUM, access completion.

Function
REQ-009 SHALL implement FSM states IDLE, ACCESS, RESP; one transaction outstanding at most.
REQ-010 SHALL drive icb_cmd_ready=1 only in IDLE; handshake = icb_cmd_valid & icb_cmd_ready.
REQ-011 SHALL on handshake latch addr, read, wdata, wmask and slot index = icb_cmd_addr[SEL_LSB+SEL_W-1:SEL_LSB].
REQ-012 SHALL ignore address bits above the select field.
REQ-013 SHALL drive slot_addr_o = {latched addr[SEL_LSB-1:2], 2'b00}; slot_wdata_o and slot_sel_o from the latched values.
REQ-014 SHALL, for an implemented slot (index < SLOT_NUM and SLOT_MASK bit set), go IDLE->ACCESS.
REQ-015 SHALL, for an unmapped slot, go IDLE->RESP with err=1, rdata=0, and assert no slot strobe.
REQ-016 SHALL in ACCESS hold slot_we_o[slot] (write) or slot_rd_o[slot] (read) high every cycle until slot_rdy_i[slot]=1; all other strobe bits stay 0.
REQ-017 SHALL in the cycle slot_rdy_i[slot]=1 capture slot_rdata_i[slot] for reads, or 0 for writes, then go ACCESS->RESP with err=0.
REQ-018 SHALL ignore slot_rdy_i bits of non-selected slots and slot_rdy_i outside ACCESS.
REQ-019 SHALL respond to writes as well as reads; every accepted command yields exactly one response.
REQ-020 SHALL in RESP hold icb_rsp_valid=1 with stable err/rdata until icb_rsp_ready=1, then go to IDLE; icb_rsp_rdata=0 whenever icb_rsp_valid=0.
REQ-021 SHALL give minimum latency: handshake cycle N, strobe cycle N+1 (slot rdy same cycle), icb_rsp_valid cycle N+2, next cmd_ready cycle N+3.

Reset
REQ-022 SHALL on rst=1 at a clk edge enter IDLE; icb_cmd_ready=1 after reset; icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0, all strobes 0, timeout counter 0.
REQ-023 SHALL on reset mid-ACCESS or mid-RESP drop the transaction; no response is issued for it.

Configuration
REQ-024 SHALL with macro SYSP_XBAR_TIMEOUT_EN defined count cycles in ACCESS from 0; when the count reaches TMO_CYC-1 without slot rdy, deassert strobes next cycle and go to RESP with err=1, rdata=0.
REQ-025 SHALL with SYSP_XBAR_TIMEOUT_EN undefined omit the counter and wait in ACCESS indefinitely; TMO_CYC unused.
REQ-026 SHALL give slot rdy priority over timeout when both occur in the same cycle: normal completion, err=0.

Verification
REQ-027 Read slot 15 offset 0x08, rdy immediate, rdata 0x12345678 -> slot_rd_o[15] high one cycle, slot_addr_o=0x08, rsp valid at N+2, rdata=0x12345678, err=0.
REQ-028 Write addr 0x20C wdata 0xA5A5A5A5 wmask 4'b0011, slot 2 rdy after 3 wait cycles -> slot_we_o[2] high 4 cycles, slot_sel_o=4'b0011, rsp err=0, rdata=0.
REQ-029 Read addr 0x500 (slot 5 masked off) -> no strobe, rsp at N+1 state RESP, err=1, rdata=0.
REQ-030 With SYSP_XBAR_TIMEOUT_EN, TMO_CYC=4, slot 0 rdy never asserted -> strobe 4 cycles, then rsp err=1; rdy in 4th cycle -> err=0.
REQ-031 icb_rsp_ready low 5 cycles after read of slot 1 -> rsp_valid and rdata stable 6 cycles, cmd_ready 0 throughout.
REQ-032 rst asserted during ACCESS -> next cycle IDLE, strobes 0, no rsp_valid; following read completes normally.

Source files
------------

// File: rtl/sysp_icb_xbar_if.sv
// ---------------------------------------------------------------------------
// sysp_icb_xbar_if
// Purpose : ICB command/response bundle used between a bus master and the
//           sysp_icb_xbar peripheral crossbar.
// Signals : icb_cmd_valid/ready, icb_cmd_addr[31:0], icb_cmd_read,
//           icb_cmd_wdata[31:0], icb_cmd_wmask[3:0]      (command channel)
//           icb_rsp_valid/ready, icb_rsp_err, icb_rsp_rdata[31:0]
//                                                        (response channel)
// Modports: master - issues commands, accepts responses
//           slave  - accepts commands, issues responses (the crossbar side)
// ---------------------------------------------------------------------------
interface sysp_icb_xbar_if;
  logic        icb_cmd_valid;
  logic        icb_cmd_ready;
  logic [31:0] icb_cmd_addr;
  logic        icb_cmd_read;
  logic [31:0] icb_cmd_wdata;
  logic [3:0]  icb_cmd_wmask;
  logic        icb_rsp_valid;
  logic        icb_rsp_ready;
  logic        icb_rsp_err;
  logic [31:0] icb_rsp_rdata;

  modport master (
    output icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
           icb_cmd_wmask, icb_rsp_ready,
    input  icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );

  modport slave (
    input  icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata,
           icb_cmd_wmask, icb_rsp_ready,
    output icb_cmd_ready, icb_rsp_valid, icb_rsp_err, icb_rsp_rdata
  );
endinterface

// File: rtl/sysp_icb_xbar.sv
// ---------------------------------------------------------------------------
// sysp_icb_xbar
// Purpose : Single-outstanding ICB to peripheral-slot bridge. The slot is
//           chosen by address field [SEL_LSB+SEL_W-1:SEL_LSB]; unmapped slots
//           get an immediate error response. A slot strobe (rd or we) stays
//           high until the slot raises its rdy bit.
// Ports   : clk, rst          - clock, synchronous active-high reset
//           icb (slave)       - ICB command/response channel
//           slot_addr_o       - word-aligned offset shared by all slots
//           slot_wdata_o      - write data shared by all slots
//           slot_sel_o        - byte mask shared by all slots
//           slot_we_o/rd_o    - one write/read strobe per slot
//           slot_rdata_i      - packed read data, slot i at [32i+31:32i]
//           slot_rdy_i        - per-slot access completion
// Option  : define SYSP_XBAR_TIMEOUT_EN to abort an access after TMO_CYC
//           cycles without rdy (error response). Undefined: waits forever.
// ---------------------------------------------------------------------------
module sysp_icb_xbar #(
  parameter int          SLOT_NUM  = 16,
  parameter int          SEL_LSB   = 8,
  parameter int          SEL_W     = 4,
  parameter logic [15:0] SLOT_MASK = 16'h800F,
  parameter int          TMO_CYC   = 255
) (
  input  logic                     clk,
  input  logic                     rst,
  sysp_icb_xbar_if.slave           icb,
  output logic [SEL_LSB-1:0]       slot_addr_o,
  output logic [31:0]              slot_wdata_o,
  output logic [3:0]               slot_sel_o,
  output logic [SLOT_NUM-1:0]      slot_we_o,
  output logic [SLOT_NUM-1:0]      slot_rd_o,
  input  logic [32*SLOT_NUM-1:0]   slot_rdata_i,
  input  logic [SLOT_NUM-1:0]      slot_rdy_i
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state, state_next;

  logic [SEL_LSB-3:0] offset_q;
  logic [SEL_W-1:0]   slot_q;
  logic               read_q;
  logic [31:0]        wdata_q;
  logic [3:0]         wmask_q;
  logic               err_q;
  logic [31:0]        rdata_q;

  logic               cmd_fire;
  logic [SEL_W-1:0]   cmd_slot;
  logic               cmd_mapped;
  logic               sel_rdy;
  logic [31:0]        sel_rdata;
  logic               timeout_hit;

  // Only the select field and the word offset matter; the rest is ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{icb.icb_cmd_addr[31:SEL_LSB+SEL_W],
                              icb.icb_cmd_addr[1:0]};

  assign cmd_fire = icb.icb_cmd_valid & icb.icb_cmd_ready;
  assign cmd_slot = icb.icb_cmd_addr[SEL_LSB+SEL_W-1:SEL_LSB];

  // A slot is mapped when it is below SLOT_NUM and its mask bit is set.
  always_comb begin
    cmd_mapped = 1'b0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      if (cmd_slot == SEL_W'(i) && SLOT_MASK[i]) cmd_mapped = 1'b1;
    end
  end

  // Pick the rdy/rdata of the latched slot; other slots are never looked at.
  always_comb begin
    sel_rdy   = 1'b0;
    sel_rdata = 32'd0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      if (slot_q == SEL_W'(i)) begin
        sel_rdy   = slot_rdy_i[i];
        sel_rdata = slot_rdata_i[32*i +: 32];
      end
    end
  end

`ifdef SYSP_XBAR_TIMEOUT_EN
  logic [15:0] tmo_cnt;

  // Counts ACCESS cycles from 0; cleared in every other state.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt <= 16'd0;
    end else if (state == ACCESS) begin
      tmo_cnt <= tmo_cnt + 16'd1;
    end else begin
      tmo_cnt <= 16'd0;
    end
  end

  // Slot rdy wins over an expiring counter in the same cycle.
  assign timeout_hit = (state == ACCESS) && !sel_rdy &&
                       (tmo_cnt == 16'(TMO_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: unmapped slots skip ACCESS and answer at once.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_fire) state_next = cmd_mapped ? ACCESS : RESP;
      end
      ACCESS: begin
        if (sel_rdy || timeout_hit) state_next = RESP;
      end
      RESP: begin
        if (icb.icb_rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Command latch and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      offset_q <= '0;
      slot_q   <= '0;
      read_q   <= 1'b0;
      wdata_q  <= 32'd0;
      wmask_q  <= 4'd0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      if (state == IDLE && cmd_fire) begin
        offset_q <= icb.icb_cmd_addr[SEL_LSB-1:2];
        slot_q   <= cmd_slot;
        read_q   <= icb.icb_cmd_read;
        wdata_q  <= icb.icb_cmd_wdata;
        wmask_q  <= icb.icb_cmd_wmask;
        err_q    <= !cmd_mapped;
        rdata_q  <= 32'd0;
      end else if (state == ACCESS && sel_rdy) begin
        err_q   <= 1'b0;
        rdata_q <= read_q ? sel_rdata : 32'd0;
      end else if (timeout_hit) begin
        err_q   <= 1'b1;
        rdata_q <= 32'd0;
      end
    end
  end

  // Exactly one strobe bit, and only while in ACCESS.
  always_comb begin
    slot_we_o = '0;
    slot_rd_o = '0;
    for (int i = 0; i < SLOT_NUM; i++) begin
      if (state == ACCESS && slot_q == SEL_W'(i)) begin
        slot_we_o[i] = !read_q;
        slot_rd_o[i] = read_q;
      end
    end
  end

  assign slot_addr_o  = {offset_q, 2'b00};
  assign slot_wdata_o = wdata_q;
  assign slot_sel_o   = wmask_q;

  assign icb.icb_cmd_ready = (state == IDLE);
  assign icb.icb_rsp_valid = (state == RESP);
  assign icb.icb_rsp_err   = (state == RESP) && err_q;
  assign icb.icb_rsp_rdata = (state == RESP) ? rdata_q : 32'd0;

endmodule

// File: tb/tb_sysp_icb_xbar.sv
// ---------------------------------------------------------------------------
// tb_sysp_icb_xbar
// Purpose : Directed, table-driven bench for sysp_icb_xbar (default slot
//           map 16'h800F, TMO_CYC=4). The slot side is modelled here: each
//           vector says after how many strobe cycles the selected slot
//           raises rdy, while every non-selected rdy bit is held high.
//           Timeout vectors are added only when SYSP_XBAR_TIMEOUT_EN is set.
// ---------------------------------------------------------------------------
module tb_sysp_icb_xbar;

  localparam int SLOT_NUM = 16;
  localparam int NEVER    = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0]              slot_addr_o;
  logic [31:0]             slot_wdata_o;
  logic [3:0]              slot_sel_o;
  logic [SLOT_NUM-1:0]     slot_we_o;
  logic [SLOT_NUM-1:0]     slot_rd_o;
  logic [32*SLOT_NUM-1:0]  slot_rdata_i;
  logic [SLOT_NUM-1:0]     slot_rdy_i;

  int checks = 0;
  int errors = 0;

  sysp_icb_xbar_if icb ();

  sysp_icb_xbar #(
    .SLOT_NUM (SLOT_NUM),
    .SEL_LSB  (8),
    .SEL_W    (4),
    .SLOT_MASK(16'h800F),
    .TMO_CYC  (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .icb         (icb.slave),
    .slot_addr_o (slot_addr_o),
    .slot_wdata_o(slot_wdata_o),
    .slot_sel_o  (slot_sel_o),
    .slot_we_o   (slot_we_o),
    .slot_rd_o   (slot_rd_o),
    .slot_rdata_i(slot_rdata_i),
    .slot_rdy_i  (slot_rdy_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        read;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          rdy_delay;
    logic [31:0] slot_data;
    int          hold_cycles;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_strobes;
    logic [7:0]  exp_slot_addr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mkVec(input logic [31:0] addr, input logic read,
                                 input logic [31:0] wdata, input logic [3:0] wmask,
                                 input int rdy_delay, input logic [31:0] slot_data,
                                 input int hold_cycles, input logic exp_err,
                                 input logic [31:0] exp_rdata, input int exp_strobes,
                                 input logic [7:0] exp_slot_addr);
    vec_t v;
    v.addr = addr; v.read = read; v.wdata = wdata; v.wmask = wmask;
    v.rdy_delay = rdy_delay; v.slot_data = slot_data; v.hold_cycles = hold_cycles;
    v.exp_err = exp_err; v.exp_rdata = exp_rdata; v.exp_strobes = exp_strobes;
    v.exp_slot_addr = exp_slot_addr;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
    end
  endtask

  task automatic idleInputs();
    icb.icb_cmd_valid = 1'b0;
    icb.icb_cmd_addr  = 32'd0;
    icb.icb_cmd_read  = 1'b0;
    icb.icb_cmd_wdata = 32'd0;
    icb.icb_cmd_wmask = 4'd0;
    icb.icb_rsp_ready = 1'b0;
    slot_rdy_i        = '0;
    slot_rdata_i      = '0;
  endtask

  // One full transaction: command, strobe/latency tracking, response hold.
  task automatic applyStimulus(input vec_t v, input string tag);
    int slot;
    int strobes;
    int lat;
    logic [SLOT_NUM-1:0] onehot;
    logic [SLOT_NUM-1:0] stray;
    logic sel_stb;
    slot   = int'(v.addr[11:8]);
    onehot = SLOT_NUM'(1) << slot;
    @(negedge clk);
    checkOutput({tag, ".cmd_ready_idle"}, 32'(icb.icb_cmd_ready), 32'd1);
    icb.icb_cmd_valid = 1'b1;
    icb.icb_cmd_addr  = v.addr;
    icb.icb_cmd_read  = v.read;
    icb.icb_cmd_wdata = v.wdata;
    icb.icb_cmd_wmask = v.wmask;
    for (int i = 0; i < SLOT_NUM; i++)
      slot_rdata_i[32*i +: 32] = (i == slot) ? v.slot_data : ~v.slot_data;
    slot_rdy_i = ~onehot;
    @(negedge clk);
    icb.icb_cmd_valid = 1'b0;
    icb.icb_cmd_addr  = 32'hFFFF_FFFF;
    icb.icb_cmd_wdata = 32'h0;
    icb.icb_cmd_wmask = 4'h0;
    strobes = 0;
    lat     = -1;
    for (int k = 0; k < 40; k++) begin
      if (icb.icb_rsp_valid) begin
        lat = k;
        break;
      end
      sel_stb = v.read ? slot_rd_o[slot] : slot_we_o[slot];
      stray   = v.read ? (slot_we_o | (slot_rd_o & ~onehot))
                       : (slot_rd_o | (slot_we_o & ~onehot));
      checkOutput({tag, ".stray_strobe"}, 32'(stray), 32'd0);
      if (sel_stb) begin
        strobes++;
        if (strobes == 1) begin
          checkOutput({tag, ".slot_addr"}, 32'(slot_addr_o), 32'(v.exp_slot_addr));
          checkOutput({tag, ".slot_sel"}, 32'(slot_sel_o), 32'(v.wmask));
          checkOutput({tag, ".slot_wdata"}, slot_wdata_o, v.wdata);
        end
        if (strobes == v.rdy_delay + 1) slot_rdy_i = slot_rdy_i | onehot;
      end
      @(negedge clk);
      slot_rdy_i = ~onehot;
    end
    checkOutput({tag, ".strobe_cycles"}, 32'(strobes), 32'(v.exp_strobes));
    checkOutput({tag, ".rsp_latency"}, 32'(lat), 32'(v.exp_strobes));
    if (lat < 0) return;
    checkOutput({tag, ".rsp_strobes_off"}, 32'(slot_rd_o | slot_we_o), 32'd0);
    checkOutput({tag, ".rsp_err"}, 32'(icb.icb_rsp_err), 32'(v.exp_err));
    checkOutput({tag, ".rsp_rdata"}, icb.icb_rsp_rdata, v.exp_rdata);
    checkOutput({tag, ".cmd_ready_busy"}, 32'(icb.icb_cmd_ready), 32'd0);
    for (int h = 0; h < v.hold_cycles; h++) begin
      @(negedge clk);
      checkOutput({tag, ".hold_valid"}, 32'(icb.icb_rsp_valid), 32'd1);
      checkOutput({tag, ".hold_rdata"}, icb.icb_rsp_rdata, v.exp_rdata);
      checkOutput({tag, ".hold_err"}, 32'(icb.icb_rsp_err), 32'(v.exp_err));
      checkOutput({tag, ".hold_cmd_ready"}, 32'(icb.icb_cmd_ready), 32'd0);
    end
    icb.icb_rsp_ready = 1'b1;
    @(negedge clk);
    icb.icb_rsp_ready = 1'b0;
    slot_rdy_i        = '0;
    checkOutput({tag, ".done_cmd_ready"}, 32'(icb.icb_cmd_ready), 32'd1);
    checkOutput({tag, ".done_rsp_valid"}, 32'(icb.icb_rsp_valid), 32'd0);
    checkOutput({tag, ".done_rdata"}, icb.icb_rsp_rdata, 32'd0);
  endtask

  // Watchdog so a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Read slot 15 off 0x08, immediate rdy.
    vecs.push_back(mkVec(32'h0000_0F08, 1'b1, 32'h0, 4'hF, 0, 32'h1234_5678, 0,
                         1'b0, 32'h1234_5678, 1, 8'h08));
    // Write slot 2 off 0x0C, rdy after 3 wait cycles.
    vecs.push_back(mkVec(32'h0000_020C, 1'b0, 32'hA5A5_A5A5, 4'b0011, 3, 32'hDEAD_BEEF, 0,
                         1'b0, 32'h0, 4, 8'h0C));
    // Read slot 5 (masked off): error, no strobe.
    vecs.push_back(mkVec(32'h0000_0500, 1'b1, 32'h0, 4'hF, 0, 32'h1111_2222, 0,
                         1'b1, 32'h0, 0, 8'h00));
    // Read slot 1 with upper address bits set, rsp_ready held low 5 cycles.
    vecs.push_back(mkVec(32'hFFFF_F1FC, 1'b1, 32'h0, 4'hF, 1, 32'hCAFE_F00D, 5,
                         1'b0, 32'hCAFE_F00D, 2, 8'hFC));
    // Write slot 0, immediate rdy.
    vecs.push_back(mkVec(32'h0000_0004, 1'b0, 32'h0123_4567, 4'hF, 0, 32'h5555_AAAA, 0,
                         1'b0, 32'h0, 1, 8'h04));
    // Read slot 3 with byte-offset bits dropped from slot address.
    vecs.push_back(mkVec(32'h0000_0303, 1'b1, 32'h0, 4'h1, 2, 32'h0BAD_F00D, 0,
                         1'b0, 32'h0BAD_F00D, 3, 8'h00));
    // Write slot 14 (masked off): error.
    vecs.push_back(mkVec(32'h0000_0E40, 1'b0, 32'h7777_8888, 4'hC, 0, 32'h0, 2,
                         1'b1, 32'h0, 0, 8'h40));
`ifdef SYSP_XBAR_TIMEOUT_EN
    // Slot 0 never ready: 4 strobe cycles then error.
    vecs.push_back(mkVec(32'h0000_0010, 1'b1, 32'h0, 4'hF, NEVER, 32'h9999_0000, 0,
                         1'b1, 32'h0, 4, 8'h10));
    // Slot 0 ready in the 4th cycle: rdy beats the timeout.
    vecs.push_back(mkVec(32'h0000_0014, 1'b1, 32'h0, 4'hF, 3, 32'h4242_4242, 0,
                         1'b0, 32'h4242_4242, 4, 8'h14));
`endif

    idleInputs();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("reset.cmd_ready", 32'(icb.icb_cmd_ready), 32'd1);
    checkOutput("reset.rsp_valid", 32'(icb.icb_rsp_valid), 32'd0);
    checkOutput("reset.rsp_err", 32'(icb.icb_rsp_err), 32'd0);
    checkOutput("reset.rsp_rdata", icb.icb_rsp_rdata, 32'd0);
    checkOutput("reset.strobes", 32'(slot_rd_o | slot_we_o), 32'd0);

    foreach (vecs[i]) applyStimulus(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of an access drops the transaction.
    @(negedge clk);
    icb.icb_cmd_valid = 1'b1;
    icb.icb_cmd_addr  = 32'h0000_0220;
    icb.icb_cmd_read  = 1'b1;
    slot_rdy_i        = '0;
    @(negedge clk);
    icb.icb_cmd_valid = 1'b0;
    checkOutput("rst_mid.strobe_on", 32'(slot_rd_o), 32'h0000_0004);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rst_mid.strobes_off", 32'(slot_rd_o | slot_we_o), 32'd0);
    checkOutput("rst_mid.rsp_valid", 32'(icb.icb_rsp_valid), 32'd0);
    checkOutput("rst_mid.cmd_ready", 32'(icb.icb_cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst_mid.no_rsp", 32'(icb.icb_rsp_valid), 32'd0);
    end
    applyStimulus(mkVec(32'h0000_0200, 1'b1, 32'h0, 4'hF, 0, 32'h600D_CAFE, 0,
                        1'b0, 32'h600D_CAFE, 1, 8'h00), "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
